l1c_inst_assoc: RTL and testbench
=================================

// Module: l1c_inst_assoc
// PURPOSE
//  Parametrised N-way set-associative, read-only L1 instruction cache between the core fetch port and the CPU wrapper.
//  Configurable line length, set count and associativity; multi-beat line refill; per-set round-robin replacement.
//  Adds a whole-cache flush (invalidate-all). Tag, valid and data storage are flop arrays inside the block.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  word width; one refill beat = one word
//  LINE_WORDS  4   words per line, power of 2, >=2
//  SETS        64  sets, power of 2
//  WAYS        2   ways, power of 2, >=1 (1 = direct-mapped)
//  Derived: OFF_W=$clog2(LINE_WORDS*DATA_W/8); IDX_W=$clog2(SETS); TAG_W=ADDR_W-IDX_W-OFF_W
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  core_req   in   1       fetch request; core holds core_addr stable while core_wait=1
//  core_addr  in   ADDR_W  fetch byte address (word aligned)
//  core_out   out  DATA_W  fetched word, valid when core_wait=0 in LOOKUP/RESP
//  core_wait  out  1       1 = stall; 0 for exactly one cycle per serviced fetch
//  flush      in   1       single-cycle pulse: invalidate every line
//  mem_req    out  1       refill request, held high through the final beat
//  mem_addr   out  ADDR_W  line-aligned refill address (offset bits zero), stable while mem_req=1
//  mem_rdata  in   DATA_W  refill beat data
//  mem_wait   in   1       0 = mem_rdata valid this cycle (one beat accepted)
//  hit_cnt    out  32      [ICACHE_PERF_CNT_EN only] lookup hits
//  miss_cnt   out  32      [ICACHE_PERF_CNT_EN only] lookup misses
// BEHAVIOUR
//  Reset: state IDLE, all valid=0, round-robin ptrs=0, beat ctr=0, mem_req=0, core_wait=1, core_out=0, counters=0.
//  Reset mid-refill aborts immediately: mem_req drops asynchronously; partial line discarded.
//  FSM IDLE -> LOOKUP on core_req. LOOKUP: compare tag of all ways of set core_addr index.
//   hit: core_wait=0, core_out=hit way word; -> IDLE. Latency req->data = 1 cycle.
//   miss & core_req: -> REFILL. core_req low in LOOKUP: -> IDLE, no refill, no count.
//  REFILL: mem_req=1; each cycle with mem_wait=0 stores mem_rdata into line buffer[beat], beat++.
//   Beats arrive in ascending word order from offset 0. After beat LINE_WORDS-1 -> RESP.
//   core_req is ignored during REFILL; the refill always completes.
//  RESP (1 cycle): mem_req=0, core_wait=0, core_out=buffer[req word]; line, tag, valid=1 written
//   into victim way at the closing edge; victim set's ptr advances (mod WAYS) only if replaced way==ptr. -> IDLE.
//  Victim: lowest-numbered invalid way; if all valid, ways[ptr[set]].
//  Multiple ways matching is illegal; assertion fires; lowest way wins.
//  Flush: in IDLE/LOOKUP clears all valid bits at next edge; a LOOKUP hit in the same cycle still
//   returns data. In REFILL/RESP flush is latched pending; on leaving RESP all valid cleared and the
//   just-refilled line is NOT left valid (RESP data still returned). Ptrs reset to 0 on flush.
//  Counters saturate at 32'hFFFF_FFFF; hit counted in LOOKUP hit, miss counted on LOOKUP->REFILL.
// CONFIGURATION
//  `ICACHE_PERF_CNT_EN defined: hit_cnt/miss_cnt ports and counters present.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package l1c_pkg: cache_state_e {IDLE,LOOKUP,REFILL,RESP}; derived-width localparam functions;
//   addr split typedef (tag/index/offset) parameterised via functions.
//  Sub-module l1c_refill_buf: beat counter + LINE_WORDS x DATA_W buffer, done flag on last beat.
//  Top holds FSM, tag/valid/data flop arrays, way compare, victim select, flush pending.
// TESTING (defaults unless noted)
//  Cold miss: fetch 0x0000_1004, mem returns 0xA0..0xA3 no stall -> mem_addr=0x0000_1000, 4 beats, core_out=0xA1 in RESP.
//  Warm hit: re-fetch 0x0000_1008 -> core_wait=0 one cycle after req, core_out=0xA2, mem_req stays 0.
//  Associativity: fill 0x1000,0x2000,0x3000 (same set 0) -> 0x1000 evicted (ptr 0); 0x2000 hits; 0x1000 misses.
//  Stalled refill: mem_wait=1 for 3 cycles between beats -> beats not lost, mem_addr stable, correct word returned.
//  Flush during REFILL: pulse flush at beat 2 -> RESP returns word; next fetch of same line misses.
//  Reset mid-refill: rst_n low at beat 1 -> mem_req=0 at once, core_wait=1; after release fetch misses; counters 0.

Source files
------------

// File: rtl/l1c_pkg.sv
// Shared types and width helpers for the L1 instruction cache.
package l1c_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } cache_state_e;

  // Byte-offset bits inside one line.
  function automatic int calc_off_w(input int line_words, input int data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

  // Byte-select bits inside one word.
  function automatic int calc_byte_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-select bits inside one line.
  function automatic int calc_word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets,
                                    input int line_words, input int data_w);
    return addr_w - calc_idx_w(sets) - calc_off_w(line_words, data_w);
  endfunction

  // A direct-mapped build still needs a one-bit way index.
  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l1c_refill_buf.sv
// Line refill buffer: counts accepted beats, stores them in word order and
// flags the cycle in which the last beat of the line is accepted.
module l1c_refill_buf
  import l1c_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  LINE_WORDS = 4,
  localparam int WORD_W     = calc_word_w(LINE_WORDS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_en,
  input  logic                               i_mem_wait,
  input  logic [DATA_W-1:0]                  i_mem_rdata,
  input  logic [WORD_W-1:0]                  i_rd_word,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]  o_line,
  output logic [DATA_W-1:0]                  o_rd_data,
  output logic                               o_done
);

  logic [WORD_W-1:0]                 r_beat;
  logic [LINE_WORDS-1:0][DATA_W-1:0] r_line;
  logic                              w_beat_ok;

  assign w_beat_ok = i_en && !i_mem_wait;
  assign o_done    = w_beat_ok && (r_beat == WORD_W'(LINE_WORDS - 1));
  assign o_line    = r_line;
  assign o_rd_data = r_line[i_rd_word];

  // Beat counter; wraps to zero after the last beat of a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      r_beat <= '0;
    end else if (w_beat_ok) begin
      r_beat <= r_beat + WORD_W'(1);
    end
  end

  // Beat storage.
  // NOTE: data storage has no reset; only the control state qualifying it (beat, valid) is reset.
  always_ff @(posedge clk) begin
    if (w_beat_ok) begin
      r_line[r_beat] <= i_mem_rdata;
    end
  end

endmodule

// File: rtl/l1c_inst_assoc.sv
// N-way set-associative read-only L1 instruction cache with multi-beat refill,
// per-set round-robin replacement and whole-cache flush.
// Build option: define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt counters.
module l1c_inst_assoc
  import l1c_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_out,
  output logic              core_wait,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wait
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W  = calc_off_w(LINE_WORDS, DATA_W);
  localparam int BYTE_W = calc_byte_w(DATA_W);
  localparam int WORD_W = calc_word_w(LINE_WORDS);
  localparam int IDX_W  = calc_idx_w(SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_W, SETS, LINE_WORDS, DATA_W);
  localparam int WAY_W  = calc_way_w(WAYS);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [BYTE_W-1:0] boff;
  } addr_t;

  cache_state_e r_state, w_state_nxt;
  addr_t        w_req, r_miss;
  logic         r_flush_pend;

  logic [SETS-1:0][WAYS-1:0]         r_valid;
  logic [SETS-1:0][WAY_W-1:0]        r_ptr;
  logic [TAG_W-1:0]                  r_tag  [SETS][WAYS];
  logic [LINE_WORDS-1:0][DATA_W-1:0] r_data [SETS][WAYS];

  logic [WAYS-1:0]                   w_hit_vec;
  logic                              w_hit;
  logic [WAY_W-1:0]                  w_hit_way;
  logic [WAY_W-1:0]                  w_victim;
  logic                              w_victim_found;
  logic                              w_lookup_hit, w_lookup_miss;
  logic                              w_clear_all;
  logic                              w_buf_done;
  logic [DATA_W-1:0]                 w_buf_word;
  logic [LINE_WORDS-1:0][DATA_W-1:0] w_buf_line;
  logic                              w_unused_boff;

  assign w_req         = addr_t'(core_addr);
  assign mem_addr      = {r_miss.tag, r_miss.idx, {OFF_W{1'b0}}};
  assign w_unused_boff = ^{w_req.boff, r_miss.boff};
  assign w_clear_all   = (flush && (r_state != REFILL)) || ((r_state == RESP) && r_flush_pend);

  l1c_refill_buf #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (r_state == REFILL),
    .i_mem_wait  (mem_wait),
    .i_mem_rdata (mem_rdata),
    .i_rd_word   (r_miss.word),
    .o_line      (w_buf_line),
    .o_rd_data   (w_buf_word),
    .o_done      (w_buf_done)
  );

  // Tag compare across all ways of the requested set; lowest matching way wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_hit_vec = '0;
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_req.idx][w] && (r_tag[w_req.idx][w] == w_req.tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way of the miss set, else the set's round-robin way.
  always_comb begin
    w_victim       = r_ptr[r_miss.idx];
    w_victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_victim_found && !r_valid[r_miss.idx][w]) begin
        w_victim_found = 1'b1;
        w_victim       = WAY_W'(w);
      end
    end
  end

  // Next-state and core/memory handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    core_wait     = 1'b1;
    core_out      = '0;
    mem_req       = 1'b0;
    w_lookup_hit  = 1'b0;
    w_lookup_miss = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (core_req) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (!core_req) begin
          w_state_nxt = IDLE;
        end else if (w_hit) begin
          core_wait    = 1'b0;
          core_out     = r_data[w_req.idx][w_hit_way][w_req.word];
          w_lookup_hit = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_lookup_miss = 1'b1;
          w_state_nxt   = REFILL;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (w_buf_done) w_state_nxt = RESP;
      end
      RESP: begin
        core_wait   = 1'b0;
        core_out    = w_buf_word;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, miss address, flush pending, valid bits and replacement pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_miss       <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
      r_ptr        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lookup_miss) r_miss <= w_req;

      if (r_state == RESP)                r_flush_pend <= 1'b0;
      else if (r_state == REFILL && flush) r_flush_pend <= 1'b1;

      if (r_state == RESP) begin
        r_valid[r_miss.idx][w_victim] <= 1'b1;
        if (w_victim == r_ptr[r_miss.idx]) begin
          r_ptr[r_miss.idx] <= (r_ptr[r_miss.idx] == WAY_W'(WAYS - 1)) ?
                               '0 : r_ptr[r_miss.idx] + WAY_W'(1);
        end
      end
      // A flush overrides the install above, so a flushed refill never stays valid.
      if (w_clear_all) begin
        r_valid <= '0;
        r_ptr   <= '0;
      end
    end
  end

  // Tag and line install into the victim way.
  always_ff @(posedge clk) begin
    if (r_state == RESP) begin
      r_tag[r_miss.idx][w_victim]  <= r_miss.tag;
      r_data[r_miss.idx][w_victim] <= w_buf_line;
    end
  end

  // A well-formed cache never holds the same tag in two ways of a set.
  a_single_hit_way : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == LOOKUP) |-> $onehot0(w_hit_vec));

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Saturating hit/miss event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_lookup_hit && (r_hit_cnt != 32'hFFFF_FFFF))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_lookup_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l1c_inst_assoc.sv
// Self-checking bench for l1c_inst_assoc (default parameters). A reference
// model tracks which lines each set holds; fetched data always equals the
// backing-memory word because the cache is read-only.
module tb_l1c_inst_assoc;

  localparam int LW   = 4;
  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req;
  logic [31:0] core_addr;
  logic [31:0] core_out;
  logic        core_wait;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_wait;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each set holds, plus round-robin pointers.
  bit          m_valid [SETS][WAYS];
  logic [21:0] m_tag   [SETS][WAYS];
  int          m_ptr   [SETS];
  int unsigned m_hits, m_misses;

  always #5 clk = ~clk;

  l1c_inst_assoc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_req  (core_req),
    .core_addr (core_addr),
    .core_out  (core_out),
    .core_wait (core_wait),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wait  (mem_wait)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // Backing memory: line 0x1000 holds 0xA0..0xA3, everything else a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h000_0100) return 32'hA0 + 32'(a[3:2]);
    return {a[31:2], 2'b00} ^ 32'h5EED_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[a[9:4]][w] && m_tag[a[9:4]][w] == a[31:10]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int s = int'(a[9:4]);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) v = m_ptr[s];
    if (v == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = a[31:10];
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_flush();
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // One fetch. stall: idle memory cycles before each beat; flush_at: beat
  // index during which flush pulses (-1 none); flush_lk: pulse flush in the
  // LOOKUP cycle; rst_at: beat index at which reset is asserted (-1 none).
  task automatic fetch(input logic [31:0] addr, input int stall, input int flush_at,
                       input bit flush_lk, input int rst_at);
    logic [31:0] line;
    int          beat;
    int          st;
    bit          pend;
    line = {addr[31:4], 4'h0};
    pend = 1'b0;
    @(negedge clk);
    core_req  = 1'b1;
    core_addr = addr;
    mem_wait  = 1'b1;
    #1 check("idle_wait", core_wait, 1);
    @(negedge clk);
    flush = flush_lk;
    #1;
    if (model_hit(addr)) begin
      check("hit_wait", core_wait, 0);
      check("hit_data", core_out, mem_word(addr));
      check("hit_no_memreq", mem_req, 0);
      m_hits++;
      if (flush_lk) model_flush();
      @(negedge clk);
      flush    = 1'b0;
      core_req = 1'b0;
      return;
    end
    check("miss_wait", core_wait, 1);
    m_misses++;
    if (flush_lk) model_flush();
    @(negedge clk);
    beat = 0;
    st   = 0;
    while (beat < LW) begin
      flush = 1'b0;
      if (beat == rst_at) begin
        rst_n    = 1'b0;
        mem_wait = 1'b1;
        #1;
        check("rst_memreq", mem_req, 0);
        check("rst_wait", core_wait, 1);
        check("rst_out", core_out, 0);
        model_reset();
        core_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (st < stall) begin
        mem_wait = 1'b1;
        st++;
      end else begin
        mem_wait  = 1'b0;
        mem_rdata = mem_word(line + 32'(4 * beat));
        if (beat == flush_at) begin
          flush = 1'b1;
          pend  = 1'b1;
        end
        beat++;
        st = 0;
      end
      #1;
      check("refill_memreq", mem_req, 1);
      check("refill_addr", mem_addr, line);
      @(negedge clk);
    end
    flush     = 1'b0;
    mem_wait  = 1'b1;
    mem_rdata = 32'h0;
    #1;
    check("resp_wait", core_wait, 0);
    check("resp_data", core_out, mem_word(addr));
    check("resp_memreq", mem_req, 0);
    model_fill(addr);
    if (pend) model_flush();
    @(negedge clk);
    core_req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst_n     = 1'b0;
    core_req  = 1'b0;
    core_addr = 32'h0;
    flush     = 1'b0;
    mem_rdata = 32'h0;
    mem_wait  = 1'b1;
    model_reset();
    #1;
    check("reset_wait", core_wait, 1);
    check("reset_memreq", mem_req, 0);
    check("reset_out", core_out, 0);
`ifdef ICACHE_PERF_CNT_EN
    check("reset_hitcnt", hit_cnt, 0);
    check("reset_misscnt", miss_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss then warm hit on the same line.
    fetch(32'h0000_1004, 0, -1, 1'b0, -1);
    fetch(32'h0000_1008, 0, -1, 1'b0, -1);
    // Three lines in set 0 of a two-way cache: round-robin eviction.
    fetch(32'h0000_2000, 0, -1, 1'b0, -1);
    fetch(32'h0000_3000, 0, -1, 1'b0, -1);
    fetch(32'h0000_2000, 0, -1, 1'b0, -1);
    fetch(32'h0000_1000, 0, -1, 1'b0, -1);
    // Stalled refill.
    fetch(32'h0000_4008, 3, -1, 1'b0, -1);
    fetch(32'h0000_400C, 0, -1, 1'b0, -1);
    // Flush during refill: data returned, line not retained.
    fetch(32'h0000_5004, 0, 2, 1'b0, -1);
    fetch(32'h0000_5004, 0, -1, 1'b0, -1);
    // Flush coinciding with a LOOKUP hit.
    fetch(32'h0000_5008, 0, -1, 1'b1, -1);
    fetch(32'h0000_500C, 0, -1, 1'b0, -1);
    // Reset mid-refill.
    fetch(32'h0000_6000, 0, -1, 1'b0, 1);
    fetch(32'h0000_6000, 0, -1, 1'b0, -1);
`ifdef ICACHE_PERF_CNT_EN
    @(negedge clk);
    #1;
    check("post_rst_hitcnt", hit_cnt, m_hits);
    check("post_rst_misscnt", miss_cnt, m_misses);
`endif

    // Randomized fetches over a few sets and tags to force evictions.
    for (int i = 0; i < 150; i++) begin
      a = {12'(i % 3) + 12'h1, 10'($urandom_range(1, 5)), 6'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'b00};
      fetch(a, $urandom_range(0, 2),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
            ($urandom_range(0, 14) == 0), -1);
    end

`ifdef ICACHE_PERF_CNT_EN
    @(negedge clk);
    #1;
    check("final_hitcnt", hit_cnt, m_hits);
    check("final_misscnt", miss_cnt, m_misses);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
